bomb_countdown: RTL and testbench

Fuse timer for the bomb FSM. A free-running prescaler produces a one-cycle one-second tick. A loadable 4-bit down-counter uses that tick to time the bomb's wait period and raises `timerEnd` when it expires. The block sits directly upstream of the bomb FSM: it consumes the FSM's `countLoadN`/`countEnable` and feeds back `OneSecPulse`/`timerEnd`. It also exports the remaining seconds for the seven-segment display.

---
 rtl/bomb_pkg.sv | 27 ++
 rtl/bomb_countdown_if.sv | 38 +++
 rtl/one_sec_gen.sv | 52 +++++
 rtl/bomb_countdown.sv | 90 +++++++++
 tb/tb_bomb_countdown.sv | 153 +++++++++++++++
 5 files changed

// File: rtl/bomb_pkg.sv
// ---------------------------------------------------------------------------
// bomb_pkg
// Shared constants for the bomb fuse timer and the bomb FSM that drives it.
//   COUNT_W              : width of the seconds counter shown on the display
//   DEFAULT_CLK_FREQ_HZ  : board clock, also the number of cycles per second
//   DEFAULT_FUSE_SECONDS : seconds loaded into the fuse on arming
//   MAX_FUSE_SECONDS     : largest value the seconds counter can hold
//   prescaler_width()    : bits needed to count 0..hz-1 (never less than 1)
// ---------------------------------------------------------------------------
package bomb_pkg;

    localparam int COUNT_W              = 4;
    localparam int DEFAULT_CLK_FREQ_HZ  = 50_000_000;
    localparam int DEFAULT_FUSE_SECONDS = 3;
    localparam int MAX_FUSE_SECONDS     = (1 << COUNT_W) - 1;

    // A one-cycle-wide prescaler would give $clog2 of 0, so clamp to 1 bit.
    function automatic int prescaler_width(input int hz);
        int w;
        w = $clog2(hz);
        if (w < 1) begin
            w = 1;
        end
        return w;
    endfunction

endpackage

// File: rtl/bomb_countdown_if.sv
// ---------------------------------------------------------------------------
// bomb_countdown_if
// Signals exchanged between the bomb FSM and the fuse timer.
//   countLoadN  : FSM -> timer, active-low synchronous load of the fuse
//   countEnable : FSM -> timer, lets the fuse count down on second ticks
//   OneSecPulse : timer -> FSM, one-cycle tick once per second
//   timerEnd    : timer -> FSM, level, high once an armed fuse reached 0
//   countDigit  : timer -> display, remaining seconds
// Modports:
//   master : the bomb FSM side
//   slave  : the fuse timer side
// ---------------------------------------------------------------------------
interface bomb_countdown_if;
    import bomb_pkg::*;

    logic               countLoadN;
    logic               countEnable;
    logic               OneSecPulse;
    logic               timerEnd;
    logic [COUNT_W-1:0] countDigit;

    modport master (
        output countLoadN,
        output countEnable,
        input  OneSecPulse,
        input  timerEnd,
        input  countDigit
    );

    modport slave (
        input  countLoadN,
        input  countEnable,
        output OneSecPulse,
        output timerEnd,
        output countDigit
    );

endinterface

// File: rtl/one_sec_gen.sv
// ---------------------------------------------------------------------------
// one_sec_gen
// Free-running prescaler producing a registered one-cycle pulse every
// CLK_FREQ_HZ clock cycles.
//   clk   : clock, rising edge
//   reset : asynchronous active-high reset
//   clear : synchronous restart of the second (prescaler and pulse to 0)
//   pulse : registered tick, high for one cycle per CLK_FREQ_HZ cycles
// ---------------------------------------------------------------------------
module one_sec_gen
    import bomb_pkg::*;
#(
    parameter int CLK_FREQ_HZ = DEFAULT_CLK_FREQ_HZ
) (
    input  logic clk,
    input  logic reset,
    input  logic clear,
    output logic pulse
);

    localparam int              PRE_W    = prescaler_width(CLK_FREQ_HZ);
    localparam logic [PRE_W-1:0] PRE_LAST = PRE_W'(CLK_FREQ_HZ - 1);

    // Below two cycles per second the pulse could never drop low again.
    if (CLK_FREQ_HZ < 2) begin : g_bad_freq
        $error("one_sec_gen: CLK_FREQ_HZ must be at least 2");
    end

    logic [PRE_W-1:0] prescale;

    // Prescaler runs regardless of whether the fuse is counting, since the
    // explode phase of the bomb still needs ticks. A clear restarts the
    // second so the first one after a fuse load is always full length; it
    // also drops a pending pulse so a load can never be followed by a
    // stale tick.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            prescale <= '0;
            pulse    <= 1'b0;
        end else if (clear) begin
            prescale <= '0;
            pulse    <= 1'b0;
        end else if (prescale == PRE_LAST) begin
            prescale <= '0;
            pulse    <= 1'b1;
        end else begin
            prescale <= prescale + PRE_W'(1);
            pulse    <= 1'b0;
        end
    end

endmodule

// File: rtl/bomb_countdown.sv
// ---------------------------------------------------------------------------
// bomb_countdown
// Fuse timer for the bomb FSM. Loads START_VALUE seconds on countLoadN,
// counts down once per second tick while countEnable is high, and raises
// timerEnd when the fuse goes from 1 to 0. Stops at 0 without wrapping.
//   clk   : clock, rising edge
//   reset : asynchronous active-high reset
//   bus   : bomb_countdown_if.slave
//           in  countLoadN, countEnable
//           out OneSecPulse, timerEnd, countDigit (all registered)
// Parameters:
//   CLK_FREQ_HZ : clock cycles per second tick (>= 2)
//   START_VALUE : seconds loaded on countLoadN (1..15)
// ---------------------------------------------------------------------------
module bomb_countdown
    import bomb_pkg::*;
#(
    parameter int CLK_FREQ_HZ = DEFAULT_CLK_FREQ_HZ,
    parameter int START_VALUE = DEFAULT_FUSE_SECONDS
) (
    input  logic             clk,
    input  logic             reset,
    bomb_countdown_if.slave  bus
);

    // A zero fuse would never raise timerEnd, and anything above the
    // counter range would silently truncate.
    if (START_VALUE < 1 || START_VALUE > MAX_FUSE_SECONDS) begin : g_bad_start
        $error("bomb_countdown: START_VALUE must be in 1..15");
    end

    localparam logic [COUNT_W-1:0] LOAD_VALUE = COUNT_W'(START_VALUE);

    logic               one_sec_pulse;
    logic               load;
    logic               decrement;
    logic [COUNT_W-1:0] digit_q;
    logic [COUNT_W-1:0] digit_d;
    logic               timer_end_q;
    logic               timer_end_d;

    assign load = !bus.countLoadN;

    one_sec_gen #(
        .CLK_FREQ_HZ (CLK_FREQ_HZ)
    ) u_one_sec_gen (
        .clk   (clk),
        .reset (reset),
        .clear (load),
        .pulse (one_sec_pulse)
    );

    // Decrement uses the registered tick, so a count step lands on the edge
    // after the tick cycle. Holding at 0 is what keeps the counter from
    // wrapping; a load always overrides a coinciding tick.
    assign decrement = !load && bus.countEnable && one_sec_pulse
                       && (digit_q != '0);

    // Next-state for the fuse counter and its expiry flag. timerEnd is only
    // ever set by the 1 -> 0 step, so after a bare reset (counter already 0)
    // it stays low until the fuse is armed and runs out.
    always_comb begin
        digit_d     = digit_q;
        timer_end_d = timer_end_q;
        if (load) begin
            digit_d     = LOAD_VALUE;
            timer_end_d = 1'b0;
        end else if (decrement) begin
            digit_d = digit_q - COUNT_W'(1);
            if (digit_q == COUNT_W'(1)) begin
                timer_end_d = 1'b1;
            end
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            digit_q     <= '0;
            timer_end_q <= 1'b0;
        end else begin
            digit_q     <= digit_d;
            timer_end_q <= timer_end_d;
        end
    end

    assign bus.OneSecPulse = one_sec_pulse;
    assign bus.timerEnd    = timer_end_q;
    assign bus.countDigit  = digit_q;

endmodule

// File: tb/tb_bomb_countdown.sv
// ---------------------------------------------------------------------------
// tb_bomb_countdown
// Directed bench for bomb_countdown with CLK_FREQ_HZ = 10, START_VALUE = 3.
// Inputs change and outputs are sampled 1 time unit after each rising edge.
// ---------------------------------------------------------------------------
module tb_bomb_countdown;

    localparam int N = 10;

    logic clk;
    logic reset;
    int   checks;
    int   failures;

    bomb_countdown_if bus ();

    bomb_countdown #(
        .CLK_FREQ_HZ (N),
        .START_VALUE (3)
    ) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    // 10-unit clock period
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Drive the FSM-side inputs, then advance the given number of rising
    // edges and settle just past the last one.
    task automatic applyStimulus(input logic loadN, input logic enable,
                                 input int cycles);
        bus.countLoadN  = loadN;
        bus.countEnable = enable;
        repeat (cycles) @(posedge clk);
        #1;
    endtask

    task automatic checkOutput(input string tag, input logic [7:0] observed,
                               input logic [7:0] expected);
        checks++;
        assert (observed === expected) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, observed, expected);
        end
    endtask

    // Check all three outputs at once
    task automatic checkAll(input string tag, input logic [3:0] digit,
                            input logic tend, input logic pulse);
        checkOutput({tag, ".digit"}, {4'h0, bus.countDigit}, {4'h0, digit});
        checkOutput({tag, ".timerEnd"}, {7'h0, bus.timerEnd}, {7'h0, tend});
        checkOutput({tag, ".pulse"}, {7'h0, bus.OneSecPulse}, {7'h0, pulse});
    endtask

    initial begin
        checks          = 0;
        failures        = 0;
        reset           = 1'b1;
        bus.countLoadN  = 1'b1;
        bus.countEnable = 1'b0;

        // 1. reset held 3 cycles, then free-running ticks with no load
        $display("[TB] reset and idle ticks");
        applyStimulus(1'b1, 1'b0, 3);
        checkAll("reset", 4'd0, 1'b0, 1'b0);
        reset = 1'b0;
        applyStimulus(1'b1, 1'b1, 9);
        checkAll("idle_e9", 4'd0, 1'b0, 1'b0);
        applyStimulus(1'b1, 1'b1, 1);
        checkAll("idle_e10", 4'd0, 1'b0, 1'b1);
        applyStimulus(1'b1, 1'b1, 1);
        checkAll("idle_e11", 4'd0, 1'b0, 1'b0);
        applyStimulus(1'b1, 1'b1, 9);
        checkAll("idle_e20", 4'd0, 1'b0, 1'b1);
        applyStimulus(1'b1, 1'b1, 10);
        checkAll("idle_e30", 4'd0, 1'b0, 1'b1);

        // 2. full countdown from a load at edge k
        $display("[TB] full countdown");
        applyStimulus(1'b0, 1'b1, 1);
        checkAll("load_k", 4'd3, 1'b0, 1'b0);
        applyStimulus(1'b1, 1'b1, 10);
        checkAll("cd_k10", 4'd3, 1'b0, 1'b1);
        applyStimulus(1'b1, 1'b1, 1);
        checkAll("cd_k11", 4'd2, 1'b0, 1'b0);
        applyStimulus(1'b1, 1'b1, 10);
        checkAll("cd_k21", 4'd1, 1'b0, 1'b0);
        applyStimulus(1'b1, 1'b1, 9);
        checkAll("cd_k30", 4'd1, 1'b0, 1'b1);
        applyStimulus(1'b1, 1'b1, 1);
        checkAll("cd_k31", 4'd0, 1'b1, 1'b0);
        applyStimulus(1'b1, 1'b1, 49);
        checkAll("hold_k80", 4'd0, 1'b1, 1'b1);
        applyStimulus(1'b1, 1'b1, 1);
        checkAll("hold_k81", 4'd0, 1'b1, 1'b0);

        // 3. reload after expiry, then pause at 2 and resume
        $display("[TB] reload after expiry and pause");
        applyStimulus(1'b0, 1'b1, 1);
        checkAll("reload_exp", 4'd3, 1'b0, 1'b0);
        applyStimulus(1'b1, 1'b1, 11);
        checkAll("pz_L11", 4'd2, 1'b0, 1'b0);
        applyStimulus(1'b1, 1'b0, 39);
        checkAll("pz_L50", 4'd2, 1'b0, 1'b1);
        applyStimulus(1'b1, 1'b0, 1);
        checkAll("pz_L51", 4'd2, 1'b0, 1'b0);
        applyStimulus(1'b1, 1'b1, 9);
        checkAll("rs_L60", 4'd2, 1'b0, 1'b1);
        applyStimulus(1'b1, 1'b1, 1);
        checkAll("rs_L61", 4'd1, 1'b0, 1'b0);

        // 4. reload while counter is 1; next tick exactly 10 edges later
        $display("[TB] reload mid-count");
        applyStimulus(1'b0, 1'b1, 1);
        checkAll("reload_M", 4'd3, 1'b0, 1'b0);
        applyStimulus(1'b1, 1'b1, 9);
        checkAll("reload_M9", 4'd3, 1'b0, 1'b0);
        applyStimulus(1'b1, 1'b1, 1);
        checkAll("reload_M10", 4'd3, 1'b0, 1'b1);

        // 5. load during the tick cycle: load wins, second restarts
        $display("[TB] load/tick collision");
        applyStimulus(1'b0, 1'b1, 1);
        checkAll("coll_M11", 4'd3, 1'b0, 1'b0);
        applyStimulus(1'b1, 1'b1, 9);
        checkAll("coll_M20", 4'd3, 1'b0, 1'b0);
        applyStimulus(1'b1, 1'b1, 1);
        checkAll("coll_M21", 4'd3, 1'b0, 1'b1);
        applyStimulus(1'b1, 1'b1, 1);
        checkAll("coll_M22", 4'd2, 1'b0, 1'b0);

        // 6. asynchronous reset between edges while counter is 2
        $display("[TB] async reset mid-count");
        #2;
        reset = 1'b1;
        #1;
        checkAll("async_rst", 4'd0, 1'b0, 1'b0);
        applyStimulus(1'b1, 1'b1, 1);
        reset = 1'b0;
        applyStimulus(1'b1, 1'b1, 9);
        checkAll("post_rst_e9", 4'd0, 1'b0, 1'b0);
        applyStimulus(1'b1, 1'b1, 1);
        checkAll("post_rst_e10", 4'd0, 1'b0, 1'b1);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
